// File: rtl/seq_mult_radix.sv
// Sequential radix-2^K N x N multiplier with signed/unsigned operands and valid/ready handshakes.
// Latency N/K+1 edges from accept to out_valid; prod is held while out_ready is low.
module seq_mult_radix #(
  parameter int N = 256,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] prod,
  output logic [1:0]     state
);

  localparam int DIGITS = N / K;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  generate
    if ((K < 1) || (K > N) || (N % K != 0)) begin : g_bad_param
      $error("seq_mult_radix: K must divide N and satisfy 1 <= K <= N");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     a_mag_q, a_mag_d;
  logic [N-1:0]     b_mag_q, b_mag_d;
  logic             neg_q, neg_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   prod_q, prod_d;

  logic [2*N-1:0]   partial;
  logic [31:0]      shamt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = MULT;
      MULT: if (cnt_q == LAST_CNT) state_d = SIGN;
      SIGN: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    prod      = prod_q;
    state     = state_q;
  end

  // One digit of the multiplier, positioned at its weight within the 2N-bit accumulator
  always_comb begin
    partial = (2*N)'(a_mag_q) * (2*N)'(b_mag_q[K-1:0]);
    shamt   = 32'(K) * 32'(cnt_q);
  end

  always_comb begin
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Magnitude of -2^(N-1) wraps to itself, which is correct as an unsigned value
          a_mag_d = (is_signed && a[N-1]) ? (~a + N'(1)) : a;
          b_mag_d = (is_signed && b[N-1]) ? (~b + N'(1)) : b;
          neg_d   = is_signed & (a[N-1] ^ b[N-1]);
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      MULT: begin
        acc_d   = acc_q + (partial << shamt);
        b_mag_d = b_mag_q >> K;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      SIGN: prod_d = neg_q ? (~acc_q + (2*N)'(1)) : acc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_seq_mult_radix.sv
// Directed and random checks of seq_mult_radix at N=256, K=4.
module tb_seq_mult_radix;
  localparam int N   = 256;
  localparam int K   = 4;
  localparam int LAT = N / K + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a, b;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] prod;
  logic [1:0]     state;

  int checks   = 0;
  int failures = 0;

  seq_mult_radix #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .prod(prod), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   va;
    logic [N-1:0]   vb;
    logic           vs;
    logic [2*N-1:0] vexp;
    string          name;
  } vec_t;

  task automatic check(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one operation, waits (bounded) for out_valid, then drains the result
  task automatic run_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tbv,
                        input logic ts, output logic [2*N-1:0] p);
    int lat;
    logic rdy_seen;
    @(negedge clk);
    check({name, " in_ready before accept"}, 512'(in_ready), 512'(1));
    a = ta; b = tbv; is_signed = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tbv; is_signed = ~ts;
    lat = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 4 * LAT) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 512'(lat), 512'(LAT));
    check({name, " in_ready low while busy"}, 512'(rdy_seen), 512'(0));
    p = prod;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[$];
  logic [2*N-1:0] p, p_hold, expv;
  logic [N-1:0]   ra, rb;
  logic           rs;

  initial begin
    vecs.push_back('{N'(5), N'(12), 1'b0, 512'h3c, "u5x12"});
    vecs.push_back('{'1, N'(2), 1'b0, {255'h0, {256{1'b1}}, 1'b0}, "u_ones_x2"});
    vecs.push_back('{'1, '1, 1'b0, {{255{1'b1}}, 1'b0, 255'h0, 1'b1}, "u_ones_sq"});
    vecs.push_back('{{4'h8, 252'h0}, N'(2), 1'b0, {255'h0, 1'b1, 256'h0}, "u_2p255x2"});
    vecs.push_back('{'1, N'(2), 1'b1, {{511{1'b1}}, 1'b0}, "s_m1x2"});
    vecs.push_back('{{1'b1, 255'h0}, {1'b1, 255'h0}, 1'b1, {2'b01, 510'h0}, "s_min_sq"});
    vecs.push_back('{~N'(2), N'(7), 1'b1, ~512'd20, "s_m3x7"});
    vecs.push_back('{N'(3), ~N'(6), 1'b1, ~512'd20, "s_3xm7"});
    vecs.push_back('{~N'(4), ~N'(4), 1'b1, 512'd25, "s_m5xm5"});
    vecs.push_back('{N'(0), '1, 1'b1, 512'd0, "s_0xm1"});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 512'(state), 512'(0));
    check("reset prod", prod, 512'd0);
    check("reset out_valid", 512'(out_valid), 512'(0));
    check("in_ready during rst", 512'(in_ready), 512'(0));
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vs, p);
      check(vecs[i].name, p, vecs[i].vexp);
    end

    // Backpressure: hold DONE for 10 cycles with in_valid toggling
    @(negedge clk);
    a = N'(9); b = N'(11); is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < 4 * LAT && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    p_hold = prod;
    check("bp prod", p_hold, 512'd99);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; a = N'(i); b = N'(i + 1);
      @(posedge clk); #1;
      check("bp prod stable", prod, p_hold);
      check("bp out_valid", 512'(out_valid), 512'(1));
      check("bp in_ready", 512'(in_ready), 512'(0));
    end
    @(negedge clk); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp done->idle state", 512'(state), 512'(0));
    check("bp no accept with done", 512'(in_ready), 512'(1));
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    check("prod kept after done", prod, 512'd99);

    // Reset in the middle of MULT
    @(negedge clk);
    a = N'(100); b = N'(200); is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid state is MULT", 512'(state), 512'(1));
    @(negedge clk); rst = 1'b1; in_valid = 1'b1; a = N'(4); b = N'(4);
    @(posedge clk); #1;
    check("midrst state", 512'(state), 512'(0));
    check("midrst prod", prod, 512'd0);
    check("midrst out_valid", 512'(out_valid), 512'(0));
    @(posedge clk); #1;
    check("rst hold no accept", 512'(state), 512'(0));
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    run_op("after rst 3x7", N'(3), N'(7), 1'b0, p);
    check("after rst 3x7", p, 512'd21);

    // Random operations against a behavioural product
    for (int i = 0; i < 24; i++) begin
      for (int w = 0; w < N / 32; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      if (i % 6 == 1) ra = {1'b1, 255'h0};
      if (i % 6 == 3) rb = '1;
      if (i % 8 == 5) ra[N-1:64] = '0;
      rs = i[0];
      if (rs) expv = {{N{ra[N-1]}}, ra} * {{N{rb[N-1]}}, rb};
      else    expv = {{N{1'b0}}, ra} * {{N{1'b0}}, rb};
      run_op("rand", ra, rb, rs, p);
      check("rand prod", p, expv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
